// File: rtl/fifo_uart_pkg.sv
// Shared state encoding, serial line levels and parity helper for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } uart_state_e;

  localparam logic IDLE_LINE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Widest data word the parity helper accepts; narrower words are zero-extended.
  localparam int unsigned PARITY_MAX_W = 32;

  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period counter: emits a one-cycle tick on the last enabled cycle of every serial bit.
module baud_tick_gen #(
  parameter int clks_per_bit_g = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(clks_per_bit_g);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(clks_per_bit_g - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic             wrap_s;

  assign wrap_s = (cnt_r == CNT_LAST);

  // Count enabled cycles within a bit, parking at zero while restart is held.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_r <= '0;
    end else if (en_i) begin
      if (restart_i || wrap_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign tick_o = en_i & ~restart_i & wrap_s;

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from an upstream FIFO and serialises them LSB first.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop bits.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int data_word_size_g = 8,
  parameter int clks_per_bit_g   = 16,
  parameter int stop_bits_g      = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clk_en_i,
  input  logic                        r_empty_i,
  input  logic [data_word_size_g-1:0] r_data_i,
  output logic                        r_en_o,
  output logic                        tx_o,
  output logic                        busy_o
);

  localparam int BIT_CNT_W = $clog2(data_word_size_g + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(data_word_size_g - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(stop_bits_g - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_ONE   = BIT_CNT_W'(1);

  uart_state_e                 state_r, state_nxt_s;
  logic [data_word_size_g-1:0] shift_r;
  logic [BIT_CNT_W-1:0]        bit_cnt_r;
  logic                        tx_r, busy_r, r_en_r;
  logic                        tx_nxt_s, busy_nxt_s, r_en_nxt_s;
  logic                        tick_s, restart_s;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                        parity_r;
`endif

  assign restart_s = (state_r == ST_IDLE) || (state_r == ST_READ) || (state_r == ST_LOAD);

  baud_tick_gen #(.clks_per_bit_g(clks_per_bit_g)) u_baud (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (clk_en_i),
    .restart_i (restart_s),
    .tick_o    (tick_s)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
    end else if (clk_en_i) begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (!r_empty_i) state_nxt_s = ST_READ; else state_nxt_s = ST_IDLE;
      ST_READ:  state_nxt_s = ST_LOAD;
      ST_LOAD:  state_nxt_s = ST_START;
      ST_START: if (tick_s) state_nxt_s = ST_DATA; else state_nxt_s = ST_START;
      ST_DATA: begin
        if (tick_s && (bit_cnt_r == LAST_DATA)) begin
`ifdef FIFO_UART_TX_PARITY_EN
          state_nxt_s = ST_PARITY;
`else
          state_nxt_s = ST_STOP;
`endif
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: if (tick_s) state_nxt_s = ST_STOP; else state_nxt_s = ST_PARITY;
`else
      ST_PARITY: state_nxt_s = ST_IDLE;
`endif
      ST_STOP:  if (tick_s && (bit_cnt_r == LAST_STOP)) state_nxt_s = ST_IDLE; else state_nxt_s = ST_STOP;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered pins line up with the state.
  // The shift register is one bit ahead, so a new data bit is always shift_r[0] at a tick.
  always_comb begin
    tx_nxt_s   = IDLE_LINE;
    busy_nxt_s = 1'b1;
    r_en_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_IDLE:   busy_nxt_s = 1'b0;
      ST_READ:   r_en_nxt_s = 1'b1;
      ST_LOAD:   tx_nxt_s   = IDLE_LINE;
      ST_START:  tx_nxt_s   = START_BIT;
      ST_DATA:   if (tick_s) tx_nxt_s = shift_r[0]; else tx_nxt_s = tx_r;
`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: tx_nxt_s   = parity_r;
`else
      ST_PARITY: tx_nxt_s   = IDLE_LINE;
`endif
      ST_STOP:   tx_nxt_s   = IDLE_LINE;
      default:   busy_nxt_s = 1'b0;
    endcase
  end

  // Registered pins; everything freezes while the global enable is low.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tx_r   <= IDLE_LINE;
      busy_r <= 1'b0;
      r_en_r <= 1'b0;
    end else if (clk_en_i) begin
      tx_r   <= tx_nxt_s;
      busy_r <= busy_nxt_s;
      r_en_r <= r_en_nxt_s;
    end
  end

  // Shift register and bit counter; the counter also paces multiple stop bits.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      shift_r   <= '0;
      bit_cnt_r <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else if (clk_en_i) begin
      case (state_r)
        ST_LOAD: begin
          shift_r   <= r_data_i;
          bit_cnt_r <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_r  <= even_parity(PARITY_MAX_W'(r_data_i));
`endif
        end
        ST_START: if (tick_s) shift_r <= shift_r >> 1;
        ST_DATA: begin
          if (tick_s) begin
            shift_r   <= shift_r >> 1;
            bit_cnt_r <= (bit_cnt_r == LAST_DATA) ? '0 : bit_cnt_r + BIT_ONE;
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            bit_cnt_r <= (bit_cnt_r == LAST_STOP) ? '0 : bit_cnt_r + BIT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_o   = tx_r;
  assign busy_o = busy_r;
  assign r_en_o = r_en_r & clk_en_i;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model, serial receiver and frame scoreboard.
module tb_fifo_uart_tx;

  localparam int DW    = 8;
  localparam int CPB   = 4;
  localparam int NSTOP = 1;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FW = 1 + DW + PAR + NSTOP;
  localparam int FL = FW * CPB;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          clk_en_i;
  logic          r_empty_i;
  logic [DW-1:0] r_data_i;
  logic          r_en_o;
  logic          tx_o;
  logic          busy_o;

  logic [DW-1:0] fifo_q[$];
  logic [FW-1:0] exp_q[$];
  int            gap_log[$];

  int            n_cmp = 0;
  int            n_err = 0;
  int            pops, busy_cycles, frames_done, rx_cnt, rx_raw, gap_cnt, last_len;
  bit            rx_active, gap_valid;
  logic [FW-1:0] rx_bits;
  logic [FW-1:0] drop_frame;
  logic          frozen;

  fifo_uart_tx #(
    .data_word_size_g(DW),
    .clks_per_bit_g  (CPB),
    .stop_bits_g     (NSTOP)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clk_en_i (clk_en_i),
    .r_empty_i(r_empty_i),
    .r_data_i (r_data_i),
    .r_en_o   (r_en_o),
    .tx_o     (tx_o),
    .busy_o   (busy_o)
  );

  initial forever #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] frame_of(input logic [DW-1:0] w);
    logic [FW-1:0] f;
    f = '1;
    f[0] = 1'b0;
    f[DW:1] = w;
`ifdef FIFO_UART_TX_PARITY_EN
    f[DW+1] = ^w;
`endif
    return f;
  endfunction

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(frame_of(w));
    r_empty_i = 1'b0;
  endtask

  // One clock: sample at the falling edge, serve pops, and run the serial receiver.
  task automatic step();
    @(negedge clk_i);
    if (!rst_i) begin
      check_eq("rst_tx", 32'(tx_o), 32'd1);
      check_eq("rst_busy", 32'(busy_o), 32'd0);
      check_eq("rst_ren", 32'(r_en_o), 32'd0);
      if (rx_active) begin
        rx_active = 1'b0;
        if (exp_q.size() > 0) drop_frame = exp_q.pop_front();
      end
    end else begin
      if (r_en_o) begin
        check_eq("pop_when_empty", 32'(r_empty_i), 32'd0);
        pops++;
        if (fifo_q.size() > 0) r_data_i = fifo_q.pop_front();
        r_empty_i = (fifo_q.size() == 0);
      end
      if (busy_o) busy_cycles++;
      if (!rx_active) begin
        if (tx_o == 1'b0) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
          rx_raw    = 0;
          rx_bits   = '0;
          if (gap_valid) gap_log.push_back(gap_cnt);
        end else begin
          gap_cnt++;
        end
      end
      if (rx_active) begin
        rx_raw++;
        if (clk_en_i) begin
          if (rx_cnt % CPB == CPB / 2) rx_bits = rx_bits | (FW'(tx_o) << (rx_cnt / CPB));
          rx_cnt++;
          if (rx_cnt == FL) begin
            rx_active = 1'b0;
            last_len  = rx_raw;
            frames_done++;
            gap_cnt   = 0;
            gap_valid = 1'b1;
            if (exp_q.size() == 0) check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            else check_eq("frame", 32'(rx_bits), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy_o || rx_active) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check_eq("done_timeout", 32'(n), 32'(budget - 1));
  endtask

  task automatic wait_rx(input int target);
    int n = 0;
    while (!(rx_active && rx_cnt == target) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check_eq("wait_rx_timeout", 32'(rx_cnt), 32'(target));
  endtask

  task automatic pop_latency();
    int n = 0;
    int p0 = pops;
    while (pops == p0 && n < 20) begin
      step();
      n++;
    end
    check_eq("pop_latency", 32'(n), 32'd1);
  endtask

  initial begin
    rst_i = 1'b0; clk_en_i = 1'b1; r_empty_i = 1'b1; r_data_i = '0;
    pops = 0; busy_cycles = 0; frames_done = 0; rx_cnt = 0; rx_raw = 0;
    gap_cnt = 0; last_len = 0; rx_active = 1'b0; gap_valid = 1'b0; rx_bits = '0;

    // Reset state, then a single 0xA5 frame.
    repeat (3) step();
    push(8'hA5);
    step();
    rst_i = 1'b1; pops = 0; busy_cycles = 0;
    pop_latency();
    wait_done(300);
    check_eq("s1_busy_cycles", 32'(busy_cycles), 32'(2 + FL));
    check_eq("s1_pops", 32'(pops), 32'd1);
    check_eq("s1_frame_len", 32'(last_len), 32'(FL));

    // Two frames whose parity differs.
    frames_done = 0;
    push(8'hA5);
    push(8'h07);
    wait_done(400);
    check_eq("s2_frames", 32'(frames_done), 32'd2);
    check_eq("s2_frame_len", 32'(last_len), 32'(FL));

    // Three preloaded words: back-to-back frames with a 3-cycle gap.
    gap_log.delete(); gap_valid = 1'b0; pops = 0; frames_done = 0;
    push(8'h07);
    push(8'h3C);
    push(8'hFF);
    wait_done(500);
    check_eq("s3_pops", 32'(pops), 32'd3);
    check_eq("s3_frames", 32'(frames_done), 32'd3);
    check_eq("s3_gap_count", 32'(gap_log.size()), 32'd2);
    foreach (gap_log[i]) check_eq("s3_gap", 32'(gap_log[i]), 32'd3);

    // Enable dropped for 10 cycles in the middle of data bit 1.
    push(8'h5A);
    wait_rx(2 * CPB + 1);
    frozen = tx_o;
    @(posedge clk_i); #1;
    clk_en_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("tx_frozen", 32'(tx_o), 32'(frozen));
    end
    @(posedge clk_i); #1;
    clk_en_i = 1'b1;
    wait_done(300);
    check_eq("s4_frame_len", 32'(last_len), 32'(FL + 10));

    // Asynchronous reset during data bit 3; the popped word is lost.
    pops = 0; frames_done = 0;
    push(8'h96);
    push(8'h3C);
    wait_rx(4 * CPB + 1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    check_eq("async_rst_tx", 32'(tx_o), 32'd1);
    check_eq("async_rst_busy", 32'(busy_o), 32'd0);
    check_eq("async_rst_ren", 32'(r_en_o), 32'd0);
    repeat (4) step();
    rst_i = 1'b1;
    pop_latency();
    wait_done(300);
    check_eq("s5_pops", 32'(pops), 32'd2);
    check_eq("s5_frames", 32'(frames_done), 32'd1);
    check_eq("s5_fifo_left", 32'(fifo_q.size()), 32'd0);

    // Empty FIFO for 100 cycles: nothing moves.
    for (int i = 0; i < 100; i++) begin
      step();
      check_eq("empty_ren", 32'(r_en_o), 32'd0);
      check_eq("empty_tx", 32'(tx_o), 32'd1);
      check_eq("empty_busy", 32'(busy_o), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter data_word_size_g, default 8: frame data bits; also the width of r_data_i.
REQ-002 Parameter clks_per_bit_g, default 16: enabled clock cycles per serial bit; legal range is 2 or more.
REQ-003 Parameter stop_bits_g, default 1: number of stop bits; legal values are 1 or 2.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-low.
REQ-006 clk_en_i  in  1  global enable; when low, all state holds.
REQ-007 r_empty_i  in  1  upstream FIFO empty flag.
REQ-008 r_data_i  in  data_word_size_g  upstream FIFO read data, valid one cycle after the read strobe.
REQ-009 r_en_o  out  1  single-cycle FIFO pop strobe.
REQ-010 tx_o  out  1  serial line; idle high.
REQ-011 busy_o  out  1  high in every state other than IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, READ, LOAD, START, DATA, PARITY and STOP, and SHALL advance only on cycles where clk_en_i=1.
REQ-013 IDLE->READ SHALL occur when r_empty_i=0; IDLE otherwise holds.
REQ-014 r_en_o SHALL be registered and SHALL be high only during the single cycle the FSM is in READ.
REQ-015 READ->LOAD SHALL take exactly one cycle.
REQ-016 In LOAD, the FSM SHALL capture r_data_i into the shift register, then go to START.
REQ-017 START SHALL drive tx_o=0 for clks_per_bit_g enabled cycles.
REQ-018 DATA SHALL shift out data_word_size_g bits, LSB first, each held for clks_per_bit_g cycles.
REQ-019 The bit counter SHALL be $clog2(data_word_size_g+1) bits wide, and the baud counter $clog2(clks_per_bit_g) bits wide.
REQ-020 STOP SHALL drive tx_o=1 for stop_bits_g*clks_per_bit_g cycles, then go to IDLE.
REQ-021 Consecutive frames SHALL be separated by exactly 3 enabled cycles of tx_o=1: the IDLE, READ and LOAD cycles.
REQ-022 A pop SHALL never be issued while r_empty_i=1.
REQ-023 r_empty_i changes after READ SHALL NOT abort the frame.
REQ-024 When clk_en_i=0, r_en_o SHALL be forced low, and tx_o, the counters and the state SHALL hold.
REQ-025 tx_o SHALL come directly from a flop, with no combinational path to the pin.

Reset
REQ-026 When rst_i=0, the block SHALL immediately set state to IDLE, tx_o to 1, busy_o to 0, r_en_o to 0, and clear all counters and the shift register.
REQ-027 A reset mid-frame SHALL abandon the frame; the word already popped is lost and SHALL NOT be re-requested.
REQ-028 The first pop after reset release SHALL occur no earlier than the second enabled rising edge.

Configuration
REQ-029 Macro FIFO_UART_TX_PARITY_EN, when defined, SHALL include the PARITY state between DATA and STOP.
REQ-030 In the PARITY state, tx_o SHALL be the even-parity bit (XOR of the data bits) for clks_per_bit_g cycles.
REQ-031 Without FIFO_UART_TX_PARITY_EN, DATA SHALL go directly to STOP, and the PARITY state and its logic SHALL be absent from the netlist.

Structure
REQ-032 A shared package fifo_uart_pkg SHALL hold the FSM state typedef, the constants IDLE_LINE=1'b1 and START_BIT=1'b0, and a parity function.
REQ-033 The FSM, shift register and bit counter SHALL be implemented in fifo_uart_tx.
REQ-034 One sub-module, baud_tick_gen, SHALL hold the clks_per_bit_g counter, with a restart input and a one-cycle tick output.

Verification
REQ-035 With data_word_size_g=8, clks_per_bit_g=4, no parity: push 0xA5, then sample tx_o once per 4 cycles. Required line sequence: 0,1,0,1,0,0,1,0,1,1. r_en_o pulses once; busy_o is high for 42 cycles (READ through the last STOP cycle).
REQ-036 With FIFO_UART_TX_PARITY_EN defined, send 0xA5 then 0x07. Required parity bits: 0 for 0xA5, 1 for 0x07. Each frame is 44 cycles from START to the end of STOP.
REQ-037 Preload 3 words with the FIFO non-empty throughout. Required: 3 frames, exactly 3 r_en_o pulses, and a 3-cycle idle-high gap between frames.
REQ-038 Drop clk_en_i low for 10 cycles in the middle of a DATA bit. Required: tx_o frozen during the gap; that bit's total duration is 4+10 cycles; the rest of the frame is unchanged.
REQ-039 Assert rst_i low during bit 3 of DATA. Required: tx_o goes to 1 asynchronously; busy_o=0 and no pop during reset; the next frame after release starts cleanly with the next FIFO word.
REQ-040 Hold r_empty_i=1 for 100 cycles. Required: r_en_o stays 0, tx_o stays 1 and busy_o stays 0 throughout.
